// File: rtl/fix_ari_pkg.sv
// Shared widths, state encoding and conversion helper
// for the fixed-point arithmetic stages.
package fix_ari_pkg;

  localparam int DATA  = 15;
  localparam int INTE  = 6;
  localparam int POIN  = 8;
  localparam int ACC_N = 8;
  localparam int MAG_W = 2*(DATA-1);
  localparam int IN_W  = MAG_W+1;
  localparam int CNT_W = $clog2(ACC_N)+1;
  localparam int ACC_W = MAG_W+1+$clog2(ACC_N);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic signed [ACC_W-1:0] sm2tc(
    input logic [IN_W-1:0] v
  );
    logic signed [ACC_W-1:0] m;
    m = signed'({{(ACC_W-MAG_W){1'b0}}, v[MAG_W-1:0]});
    return v[MAG_W] ? -m : m;
  endfunction

endpackage

// File: rtl/fix_ari_if.sv
// Product stream in, rounded result out, both
// valid/ready handshaked.
interface fix_ari_if;
  import fix_ari_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATA-1:0]  out_data;
  logic             out_sat;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_cnt
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_cnt
  );

endinterface

// File: rtl/fix_ari_rnd_sat.sv
// Two's-complement accumulator to sign-magnitude operand,
// round half away from zero, saturate on overflow.
module fix_ari_rnd_sat
  import fix_ari_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  output logic [DATA-1:0]         o_data,
  output logic                    o_sat
);

  localparam int R_W = ACC_W-POIN+1;
  localparam logic [ACC_W:0] HALF =
    (ACC_W+1)'(1) << (POIN-1);
  localparam logic [R_W-1:0] MAX_M =
    R_W'((1 << (DATA-1)) - 1);

  logic             w_neg;
  logic [ACC_W-1:0] w_mag;
  logic [ACC_W:0]   w_sum;
  logic [R_W-1:0]   w_r;
  logic             w_sign;

  assign w_neg  = i_acc[ACC_W-1];
  assign w_mag  = w_neg ? 32'(-i_acc) : 32'(i_acc);
  assign w_sum  = {1'b0, w_mag} + HALF;
  assign w_r    = w_sum[ACC_W:POIN];
  assign o_sat  = (w_r > MAX_M);
  // zero never carries a sign, so -0 cannot escape
  assign w_sign = w_neg & (w_r != '0);
  assign o_data = o_sat ? {w_sign, MAX_M[DATA-2:0]}
                        : {w_sign, w_r[DATA-2:0]};

endmodule

// File: rtl/fix_ari_acc.sv
// Frame accumulator: sums sign-magnitude products and
// emits one rounded, saturated operand per frame.
module fix_ari_acc
  import fix_ari_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  fix_ari_if.slave bus
);

  state_t                  r_state;
  state_t                  w_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_in_rdy;
  logic                    r_out_vld;
  logic [DATA-1:0]         r_odata;
  logic                    r_osat;
  logic [CNT_W-1:0]        r_ocnt;
  logic                    w_hs;
  logic                    w_end;
  logic [DATA-1:0]         w_rdata;
  logic                    w_rsat;

  fix_ari_rnd_sat u_rnd (
    .i_acc  (r_acc),
    .o_data (w_rdata),
    .o_sat  (w_rsat)
  );

  always_comb begin
    w_nxt = r_state;
    w_hs  = 1'b0;
    w_end = 1'b0;
    unique case (r_state)
      ACC: begin
        w_hs  = bus.in_valid;
        w_end = w_hs & (bus.in_last |
                (r_cnt == CNT_W'(ACC_N-1)));
        if (w_end) w_nxt = ROUND;
      end
      ROUND: w_nxt = HOLD;
      HOLD:  if (bus.out_ready) w_nxt = ACC;
      default: w_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_odata   <= '0;
      r_osat    <= 1'b0;
      r_ocnt    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_in_rdy  <= (w_nxt == ACC);
      r_out_vld <= (w_nxt == HOLD);
      if (w_hs) begin
        r_acc <= r_acc + sm2tc(bus.in_data);
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ROUND) begin
        r_odata <= w_rdata;
        r_osat  <= w_rsat;
        r_ocnt  <= r_cnt;
        r_acc   <= '0;
        r_cnt   <= '0;
      end
    end
  end

  assign bus.in_ready  = r_in_rdy;
  assign bus.out_valid = r_out_vld;
  assign bus.out_data  = r_odata;
  assign bus.out_sat   = r_osat;
  assign bus.out_cnt   = r_ocnt;

endmodule

// File: doc/fix_ari_acc.md
# fix_ari_acc

Downstream consumer of the fixed-point multiplier stage. It accepts a stream of sign-magnitude products (sign + 28-bit magnitude, 2·POIN fractional bits) and accumulates each frame of up to ACC_N products in two's complement. At frame end it rounds and saturates the sum back to the 15-bit sign-magnitude operand format (1 sign, INTE integer, POIN fraction). The result is offered on a valid/ready output port, so dot products can feed the next arithmetic stage.

## Interface
- DATA, 15, operand width (sign + INTE + POIN).
- INTE, 6, integer bits of operand format.
- POIN, 8, fraction bits of operand format.
- ACC_N, 8, max products per frame (power of two, ≥2).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product beat present.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  beat closes the frame (qualified by in_valid & in_ready).
- in_data  in  2·(DATA-1)+1 (29)  bit 28 sign, bits 27:0 magnitude, 16 fraction bits.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_data  out  DATA (15)  bit 14 sign, bits 13:0 magnitude, POIN fraction bits.
- out_sat  out  1  result saturated.
- out_cnt  out  $clog2(ACC_N)+1  number of beats in the frame.

## Operation
- Derived constants: MAG_W = 2·(DATA-1) = 28; ACC_W = MAG_W+1+$clog2(ACC_N) = 32 (signed).
- Beat conversion: two's complement = sign ? -mag : +mag, sign-extended to ACC_W. A negative zero (sign=1, mag=0) adds 0.
- FSM states: ACC, ROUND, HOLD.
  - ACC: in_ready=1. On handshake, acc += beat and cnt += 1. The frame ends when in_last=1 or cnt reaches ACC_N-1 before the add (i.e. the ACC_N-th beat). If both conditions hold, they count as a single frame end. Frame end → ROUND.
  - ROUND: in_ready=0. Registers out_data, out_sat and out_cnt from acc, then clears acc and cnt. → HOLD.
  - HOLD: in_ready=0, out_valid=1. Outputs are stable until out_ready=1; then → ACC.
- Round/saturate:
  - Magnitude m = |acc|.
  - r = (m + 2^(POIN-1)) >> POIN, which is round-half-away-from-zero.
  - If r > 2^(DATA-1)-1, the magnitude becomes 0x3FFF and out_sat=1.
  - Sign = acc<0 and r≠0. A result of zero is always +0.
- No accumulator overflow is possible: ACC_N beats of maximum magnitude fit in ACC_W.
- Reset in any state discards the partial frame and any held result.

## Timing
- Reset values:
  - State = ACC, acc = 0, cnt = 0.
  - in_ready = 1, out_valid = 0.
  - out_data = 0, out_sat = 0, out_cnt = 0.
- Latency: frame-end beat accepted at edge t → ROUND during cycle t..t+1 → out_valid=1 from edge t+1 (two cycles after that beat was presented).
- The output handshake completes on the edge where out_valid & out_ready are both 1. in_ready rises on that same edge, so the earliest next beat is accepted one cycle later.
- Throughput: one beat per cycle inside a frame, plus a minimum 2-cycle bubble per frame.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- in_ready does not depend combinationally on out_ready. All outputs are registered.

## Structure
- Shared package fix_ari_pkg holds:
  - DATA/INTE/POIN defaults and MAG_W.
  - Function sm2tc (sign-magnitude to two's complement, ACC_W).
  - FSM state enum {ACC, ROUND, HOLD}.
- The multiplier stage uses the same package for its widths.
- One combinational sub-module, fix_ari_rnd_sat: ACC_W two's-complement in → 15-bit sign-magnitude plus sat flag out. It is reusable by other stages.

## Test plan
- Full frame, no stall:
  - Stimulus: 8 beats of 29'h0030000 (+3.0) with out_ready=1.
  - Response: out_data=15'h1800 (24.0), out_sat=0, out_cnt=8, out_valid exactly 2 cycles after the 8th beat.
- Cancellation:
  - Stimulus: beats 29'h0030000 then 29'h10030000 with in_last on the second.
  - Response: out_data=15'h0000 (not 15'h4000), out_cnt=2.
- Rounding:
  - 29'h0000080 alone with in_last → 15'h0001.
  - 29'h000007F → 15'h0000.
  - 29'h10000080 → 15'h4001.
- Saturation:
  - 8 beats of 29'h0FFFFFFF → out_data=15'h3FFF, out_sat=1.
  - Same beats with sign=1 → 15'h7FFF, out_sat=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises.
  - Response: out_data stable and in_ready=0 throughout. The in_valid beats presented meanwhile are not accepted. in_ready=1 the cycle after the handshake.
- Reset mid-frame:
  - Stimulus: 3 beats of +3.0, assert rst for 1 cycle, then 1 beat of +1.0 (29'h0010000) with in_last.
  - Response: out_data=15'h0100, out_cnt=1.
